trace_dump_ctrl: RTL and testbench
==================================

TRACE_DUMP_CTRL -- requirements
Module: trace_dump_ctrl

Interface
REQ-001 The block SHALL have the following ports (name direction width meaning), clock and reset first:
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 dump_req  in  1  one-cycle request to dump the captured trace.
REQ-005 dump_abort  in  1  abort an in-progress dump.
REQ-006 cap_done  in  1  capture-complete flag; trace RAM contents are stable while high.
REQ-007 trace_end  in  9  address of the last sample written by the capture engine.
REQ-008 cap_en, cap_we  in  1 each  capture engine RAM enable and write enable.
REQ-009 cap_addr  in  9  capture engine RAM address.
REQ-010 ram_en, ram_we  out  1 each  shared trace RAM enable and write enable.
REQ-011 ram_addr  out  9  shared trace RAM address.
REQ-012 ram_rdata  in  8  RAM read data, valid one cycle after a read enable.
REQ-013 tx_data  out  8  byte to the UART transmitter.
REQ-014 trmt  out  1  one-cycle transmit strobe.
REQ-015 tx_done  in  1  UART finished the current byte.
REQ-016 dump_busy  out  1  high from dump accept until return to IDLE.
REQ-017 dump_done, dump_err, clr_cap_done  out  1 each  one-cycle status pulses.

Function
REQ-018 RAM arbitration: when cap_en=1, ram_en/ram_we/ram_addr SHALL equal cap_en/cap_we/cap_addr in the same cycle (combinational, capture has absolute priority).
REQ-019 When cap_en=0, the RAM port SHALL be driven by the dump engine; ram_we SHALL be 0 whenever the dump engine owns the port.
REQ-020 States: IDLE, RD, RDWAIT, SEND, TXWAIT, DONE.
REQ-021 IDLE: dump_req=1 with cap_done=1 -> RD; rd_ptr loads trace_end+1 mod 512; byte count clears to 0.
REQ-022 IDLE: dump_req=1 with cap_done=0 -> dump_err=1 for one cycle; stay in IDLE.
REQ-023 RD: if cap_en=0, assert the dump read (ram_en=1, ram_addr=rd_ptr) -> RDWAIT; if cap_en=1, stall in RD with no dump read.
REQ-024 RDWAIT: capture ram_rdata into tx_data -> SEND (read-to-data latency exactly 1 cycle).
REQ-025 SEND: trmt=1 for exactly one cycle -> TXWAIT.
REQ-026 TXWAIT: on tx_done=1, rd_ptr += 1 (wraps 511->0) and count += 1 (10-bit); if the new count is 512 -> DONE, else -> RD.
REQ-027 DONE: dump_done=1 and clr_cap_done=1 for one cycle -> IDLE.
REQ-028 Exactly 512 bytes SHALL be sent per dump, oldest first: trace_end+1 ... trace_end, wrapping across address 511->0.
REQ-029 tx_data SHALL hold its value from RDWAIT until the next RDWAIT.
REQ-030 dump_req while dump_busy=1 SHALL be ignored: no restart, no error.
REQ-031 dump_abort in any non-IDLE state SHALL go to IDLE on the next edge, with no dump_done or clr_cap_done; trmt SHALL be 0 in the abort cycle.
REQ-032 If dump_abort and dump_req are both high in IDLE, dump_abort SHALL win: no dump starts and no dump_err is issued.
REQ-033 dump_busy SHALL be 1 in every state other than IDLE.
REQ-034 cap_done falling mid-dump SHALL NOT affect the dump.

Reset
REQ-035 On rst_n=0, asynchronously: state=IDLE, rd_ptr=0, count=0, tx_data=0x00, trmt=0, dump_busy=0, dump_done=0, dump_err=0, clr_cap_done=0.
REQ-036 On rst_n=0, the RAM port outputs SHALL follow the capture inputs (REQ-018), otherwise en=0, we=0, addr=0.
REQ-037 Reset asserted mid-dump SHALL abandon the dump with no status pulse; the first dump_req after reset SHALL start a fresh dump.

Verification
REQ-038 cap_done=1, trace_end=0x1FF, tx_done returned 3 cycles after each trmt, RAM[i]=i[7:0] -> 512 trmt pulses; bytes 0x00..0xFF twice, in order; then dump_done and clr_cap_done pulse once.
REQ-039 trace_end=0x0FF -> first byte read from address 0x100, wraps 0x1FF->0x000, last byte read from address 0x0FF.
REQ-040 dump_req with cap_done=0 -> single dump_err pulse, dump_busy stays 0, no RAM read.
REQ-041 cap_en=1 held for 5 cycles while in RD -> RAM port shows the capture signals, no dump read for those 5 cycles, dump resumes at the same rd_ptr, no byte skipped or duplicated.
REQ-042 dump_abort after byte 10 -> IDLE next cycle, no dump_done; a new dump_req restarts from trace_end+1.
REQ-043 rst_n pulsed low during TXWAIT -> all outputs at reset values immediately; a later dump completes all 512 bytes.

Source files
------------

// File: rtl/trace_dump_ctrl.sv
// Trace dump controller: streams the 512-entry trace RAM out to a UART, oldest sample first,
// while giving the capture engine absolute priority on the shared RAM port.
module trace_dump_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dump_req,
   input  logic       dump_abort,
   input  logic       cap_done,
   input  logic [8:0] trace_end,
   input  logic       cap_en,
   input  logic       cap_we,
   input  logic [8:0] cap_addr,
   output logic       ram_en,
   output logic       ram_we,
   output logic [8:0] ram_addr,
   input  logic [7:0] ram_rdata,
   output logic [7:0] tx_data,
   output logic       trmt,
   input  logic       tx_done,
   output logic       dump_busy,
   output logic       dump_done,
   output logic       dump_err,
   output logic       clr_cap_done
);

   typedef enum logic [2:0] {IDLE, RD, RDWAIT, SEND, TXWAIT, DONE} state_t;

   state_t     state, state_nx;
   logic [8:0] rd_ptr, rd_ptr_nx;
   logic [9:0] byte_cnt, byte_cnt_nx, byte_cnt_inc;
   logic [7:0] tx_data_nx;
   logic       dump_err_nx;
   logic       dump_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         byte_cnt <= '0;
         tx_data  <= '0;
         dump_err <= 1'b0;
      end else begin
         state    <= state_nx;
         rd_ptr   <= rd_ptr_nx;
         byte_cnt <= byte_cnt_nx;
         tx_data  <= tx_data_nx;
         dump_err <= dump_err_nx;
      end
   end

   assign byte_cnt_inc = byte_cnt + 10'd1;

   always_comb begin
      state_nx     = state;
      rd_ptr_nx    = rd_ptr;
      byte_cnt_nx  = byte_cnt;
      tx_data_nx   = tx_data;
      dump_err_nx  = 1'b0;
      dump_rd      = 1'b0;
      trmt         = 1'b0;
      dump_done    = 1'b0;
      clr_cap_done = 1'b0;

      // Abort overrides every active state, suppressing that state's strobes.
      if (state != IDLE && dump_abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (dump_req && !dump_abort) begin
                  if (cap_done) begin
                     state_nx    = RD;
                     rd_ptr_nx   = trace_end + 9'd1;
                     byte_cnt_nx = '0;
                  end else begin
                     dump_err_nx = 1'b1;
                  end
               end
            end
            RD: begin
               if (!cap_en) begin
                  dump_rd  = 1'b1;
                  state_nx = RDWAIT;
               end
            end
            RDWAIT: begin
               tx_data_nx = ram_rdata;
               state_nx   = SEND;
            end
            SEND: begin
               trmt     = 1'b1;
               state_nx = TXWAIT;
            end
            TXWAIT: begin
               if (tx_done) begin
                  rd_ptr_nx   = rd_ptr + 9'd1;
                  byte_cnt_nx = byte_cnt_inc;
                  state_nx    = (byte_cnt_inc == 10'd512) ? DONE : RD;
               end
            end
            DONE: begin
               dump_done    = 1'b1;
               clr_cap_done = 1'b1;
               state_nx     = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign dump_busy = (state != IDLE);

   assign ram_en   = cap_en | dump_rd;
   assign ram_we   = cap_en & cap_we;
   assign ram_addr = cap_en ? cap_addr : (dump_rd ? rd_ptr : '0);

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Directed bench for trace_dump_ctrl: arbitration vector table plus full-dump, stall,
// abort, error and mid-dump reset sequences against a synchronous RAM and UART model.
module tb_trace_dump_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, dump_req, dump_abort, cap_done, cap_en, cap_we;
   logic [8:0] trace_end, cap_addr, ram_addr;
   logic       ram_en, ram_we, trmt, dump_busy, dump_done, dump_err, clr_cap_done;
   logic [7:0] ram_rdata, tx_data;
   logic       tx_done = 1'b0;

   int n_vec  = 0;
   int n_fail = 0;

   logic [7:0] mem [512];
   logic [7:0] bytes_q [$];
   logic [8:0] addr_q [$];
   int done_cnt, clr_cnt, err_cnt, tx_cnt;
   logic busy_seen;

   trace_dump_ctrl dut (
      .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_abort(dump_abort),
      .cap_done(cap_done), .trace_end(trace_end), .cap_en(cap_en), .cap_we(cap_we),
      .cap_addr(cap_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_rdata(ram_rdata), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
      .dump_busy(dump_busy), .dump_done(dump_done), .dump_err(dump_err),
      .clr_cap_done(clr_cap_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];

   // UART: tx_done pulses for one cycle, three cycles after each trmt
   initial tx_cnt = 0;
   always @(negedge clk) begin
      tx_done = 1'b0;
      if (tx_cnt != 0) begin
         tx_cnt--;
         if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (trmt) tx_cnt = 3;
   end

   always @(negedge clk) begin
      if (trmt) bytes_q.push_back(tx_data);
      if (ram_en && !cap_en) addr_q.push_back(ram_addr);
      if (dump_done) done_cnt++;
      if (clr_cap_done) clr_cnt++;
      if (dump_err) err_cnt++;
      if (dump_busy) busy_seen = 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      bytes_q.delete();
      addr_q.delete();
      done_cnt = 0; clr_cnt = 0; err_cnt = 0;
      busy_seen = 1'b0;
   endtask

   task automatic start_dump(input logic [8:0] te, input logic cd);
      @(posedge clk); #1;
      trace_end = te; cap_done = cd; dump_req = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input string tag);
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk); #1;
         if (bytes_q.size() >= n) break;
      end
      check({tag, " reach_bytes"}, int'(bytes_q.size() >= n), 1);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) break;
      end
      check({tag, " done_seen"}, int'(done_cnt > 0), 1);
      repeat (3) @(negedge clk);
      check({tag, " idle_after"}, int'(dump_busy), 0);
   endtask

   task automatic verify(input logic [8:0] te, input string tag);
      int bad_b = 0;
      int bad_a = 0;
      logic [8:0] ea;
      check({tag, " n_bytes"}, bytes_q.size(), 512);
      check({tag, " n_reads"}, addr_q.size(), 512);
      for (int k = 0; k < 512; k++) begin
         ea = te + 9'(k) + 9'd1;
         if (k < bytes_q.size() && bytes_q[k] != ea[7:0]) bad_b++;
         if (k < addr_q.size() && addr_q[k] != ea) bad_a++;
      end
      check({tag, " byte_order_errs"}, bad_b, 0);
      check({tag, " addr_order_errs"}, bad_a, 0);
      check({tag, " dump_done_cnt"}, done_cnt, 1);
      check({tag, " clr_cap_done_cnt"}, clr_cnt, 1);
      check({tag, " dump_err_cnt"}, err_cnt, 0);
   endtask

   typedef struct {
      logic       rst_n;
      logic       cap_en;
      logic       cap_we;
      logic [8:0] cap_addr;
      logic [11:0] exp;   // {ram_en, ram_we, ram_addr, dump_busy}
   } vec_t;

   vec_t tbl [7];

   initial begin
      int got;
      int nb;
      int stall_bad;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 9'h000, {1'b0, 1'b0, 9'h000, 1'b0}};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 9'h155, {1'b1, 1'b1, 9'h155, 1'b0}};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 9'h0AA, {1'b1, 1'b0, 9'h0AA, 1'b0}};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 9'h1FF, {1'b0, 1'b0, 9'h000, 1'b0}};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 9'h1FF, {1'b1, 1'b1, 9'h1FF, 1'b0}};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 9'h001, {1'b1, 1'b0, 9'h001, 1'b0}};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 9'h123, {1'b0, 1'b0, 9'h000, 1'b0}};

      for (int i = 0; i < 512; i++) mem[i] = 8'(i);
      rst_n = 1'b0; dump_req = 1'b0; dump_abort = 1'b0; cap_done = 1'b0;
      cap_en = 1'b0; cap_we = 1'b0; cap_addr = '0; trace_end = '0;
      clear_mon();
      #12;
      check("reset_state", int'({tx_data, trmt, dump_busy, dump_done, dump_err, clr_cap_done}), 0);

      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst_n; cap_en = tbl[i].cap_en;
         cap_we = tbl[i].cap_we; cap_addr = tbl[i].cap_addr;
         #3;
         check($sformatf("arb_vec%0d", i), int'({ram_en, ram_we, ram_addr, dump_busy}),
               int'(tbl[i].exp));
      end
      @(posedge clk); #1;
      cap_en = 1'b0; cap_we = 1'b0; cap_addr = '0;

      // Full dump, trace_end=0x1FF, with a redundant dump_req mid-dump
      clear_mon();
      start_dump(9'h1FF, 1'b1);
      wait_bytes(100, "A");
      @(posedge clk); #1; dump_req = 1'b1;
      @(posedge clk); #1; dump_req = 1'b0;
      wait_done("A");
      verify(9'h1FF, "A");

      // Request without a completed capture
      clear_mon();
      start_dump(9'h000, 1'b0);
      repeat (6) @(negedge clk);
      #1;
      check("B dump_err_cnt", err_cnt, 1);
      check("B busy_seen", int'(busy_seen), 0);
      check("B n_reads", addr_q.size(), 0);

      // Abort and request together in IDLE
      clear_mon();
      @(posedge clk); #1;
      cap_done = 1'b1; dump_req = 1'b1; dump_abort = 1'b1;
      @(posedge clk); #1;
      dump_req = 1'b0; dump_abort = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("C busy_seen", int'(busy_seen), 0);
      check("C dump_err_cnt", err_cnt, 0);

      // Capture stall in RD, with cap_done dropping mid-dump
      clear_mon();
      start_dump(9'h1FF, 1'b1);
      @(posedge clk); #1; cap_done = 1'b0;
      wait_bytes(3, "D");
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (tx_done) begin got = 1; break; end
      end
      check("D tx_done_seen", got, 1);
      @(posedge clk); #1;
      cap_en = 1'b1; cap_we = 1'b0; cap_addr = 9'h0AA;
      nb = bytes_q.size();
      stall_bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (!(ram_en && !ram_we && ram_addr == 9'h0AA && dump_busy && !trmt)) stall_bad++;
      end
      check("D stall_port_errs", stall_bad, 0);
      @(posedge clk); #1;
      cap_en = 1'b0; cap_addr = '0;
      check("D no_tx_in_stall", bytes_q.size(), nb);
      wait_done("D");
      verify(9'h1FF, "D");

      // Abort after byte 10, then restart with trace_end=0x0FF
      clear_mon();
      start_dump(9'h0FF, 1'b1);
      wait_bytes(10, "E");
      @(posedge clk); #1; dump_abort = 1'b1;
      @(negedge clk);
      check("E trmt_in_abort", int'(trmt), 0);
      @(posedge clk); #1; dump_abort = 1'b0;
      @(negedge clk);
      check("E busy_after_abort", int'(dump_busy), 0);
      repeat (8) @(negedge clk);
      #1;
      check("E abort_done_cnt", done_cnt + clr_cnt, 0);
      clear_mon();
      start_dump(9'h0FF, 1'b1);
      wait_done("E");
      check("E first_addr", (addr_q.size() > 0) ? int'(addr_q[0]) : -1, 'h100);
      verify(9'h0FF, "E");

      // Reset pulse during TXWAIT, then a fresh complete dump
      clear_mon();
      start_dump(9'h1FF, 1'b1);
      wait_bytes(5, "F");
      @(posedge clk); #2; rst_n = 1'b0;
      #1;
      check("F reset_outputs",
            int'({tx_data, trmt, dump_busy, dump_done, dump_err, clr_cap_done, ram_en, ram_we, ram_addr}), 0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      check("F no_status_after_reset", done_cnt + clr_cnt, 0);
      clear_mon();
      start_dump(9'h1FF, 1'b1);
      wait_done("F");
      verify(9'h1FF, "F");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
